// File: rtl/coin_acceptor.sv
// coin_acceptor: conditions raw coin-mech sensor levels for vending_machine.
//
// Each raw sensor level passes through a two-flop synchroniser and then a
// per-channel debounce counter. The rising edge of a debounced level is a coin
// "event". A two-state FSM turns events into registered single-cycle
// coin_5 / coin_10 / reject pulses and enforces a hold-off window after every
// pulse. audit_total keeps a saturating sum of accepted coin value.
//
// Output protocol: there is no handshake. coin_5, coin_10 and reject are
// one-cycle pulses, at most one high in any cycle. vending_machine samples them
// on every clock and has no way to stall them. accept_en is read only in the
// cycle an event is detected.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   raw_5        asynchronous 5-unit sensor level
//   raw_10       asynchronous 10-unit sensor level
//   accept_en    1 = coins may be accepted (from vending_machine)
//   coin_5       one-cycle pulse, accepted 5-unit coin
//   coin_10      one-cycle pulse, accepted 10-unit coin
//   reject       one-cycle pulse, coin diverted to return chute
//   busy         high while in HOLDOFF (exposes FSM state)
//   audit_total  saturating sum of accepted coin values
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_5,
  input  logic       raw_10,
  input  logic       accept_en,
  output logic       coin_5,
  output logic       coin_10,
  output logic       reject,
  output logic       busy,
  output logic [7:0] audit_total
);

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES);

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  // Channel index 0 = 5-unit sensor, 1 = 10-unit sensor.
  logic [1:0] meta;
  logic [1:0] s;
  logic [1:0] filt;
  logic [1:0] filt_q;
  logic [3:0] dcnt [2];
  logic [1:0] rise;

  state_t     state, state_n;
  logic [3:0] hcnt, hcnt_n;
  logic       coin_5_n, coin_10_n, reject_n;
  logic [7:0] audit_n;
  logic [8:0] audit_sum;

  // Synchroniser and debounce. The filtered level changes on the edge that
  // sees the DEBOUNCE_CYCLES-th consecutive mismatching sample, so a shorter
  // glitch clears the counter before it can flip the level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta   <= '0;
      s      <= '0;
      filt   <= '0;
      filt_q <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      meta   <= {raw_10, raw_5};
      s      <= meta;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          filt[i] <= s[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 4'd1;
        end
      end
    end
  end

  // Only the 0->1 transition of a filtered level is an event.
  assign rise = filt & ~filt_q;

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    coin_5_n  = 1'b0;
    coin_10_n = 1'b0;
    reject_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise != 2'b00) begin
          state_n = HOLDOFF;
          hcnt_n  = HOLD_LOAD;
          // Simultaneous coins cannot be told apart reliably; return both.
          if (rise == 2'b11 || !accept_en) reject_n  = 1'b1;
          else if (rise[0])                coin_5_n  = 1'b1;
          else                             coin_10_n = 1'b1;
        end
      end
      HOLDOFF: begin
        // Events here are rejected but do not extend the window.
        reject_n = |rise;
        hcnt_n   = hcnt - 4'd1;
        if (hcnt == 4'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Audit total updates on the same edge that raises the coin pulse.
  always_comb begin
    audit_sum = {1'b0, audit_total};
    if (coin_5_n)       audit_sum = {1'b0, audit_total} + 9'd5;
    else if (coin_10_n) audit_sum = {1'b0, audit_total} + 9'd10;
    audit_n = audit_sum[8] ? 8'hFF : audit_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      coin_5      <= 1'b0;
      coin_10     <= 1'b0;
      reject      <= 1'b0;
      audit_total <= '0;
    end else begin
      state       <= state_n;
      hcnt        <= hcnt_n;
      coin_5      <= coin_5_n;
      coin_10     <= coin_10_n;
      reject      <= reject_n;
      audit_total <= audit_n;
    end
  end

  assign busy = (state == HOLDOFF);

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3).
// A negedge monitor accumulates pulse counts and the cycle of the most recent
// pulse; the directed sequence compares deltas against hand-computed values.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_5 = 1'b0;
  logic       raw_10 = 1'b0;
  logic       accept_en = 1'b1;
  logic       coin_5, coin_10, reject, busy;
  logic [7:0] audit_total;

  int nvec = 0;
  int nerr = 0;

  // Clock and cycle counter: cyc = number of rising edges so far.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .raw_5(raw_5), .raw_10(raw_10),
    .accept_en(accept_en), .coin_5(coin_5), .coin_10(coin_10),
    .reject(reject), .busy(busy), .audit_total(audit_total)
  );

  // Monitor, sampled away from the active edge.
  int n5 = 0, n10 = 0, nrej = 0, nbusy = 0, nexcl = 0;
  int last5 = -1, last10 = -1, lastr = -1;
  always @(negedge clk) begin
    if (coin_5 === 1'b1)  begin n5++;   last5  = cyc; end
    if (coin_10 === 1'b1) begin n10++;  last10 = cyc; end
    if (reject === 1'b1)  begin nrej++; lastr  = cyc; end
    if (busy === 1'b1) nbusy++;
    if ((int'(coin_5) + int'(coin_10) + int'(reject)) > 1) nexcl++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
  endtask

  int k;
  int b5, b10, br, bb;

  initial begin
    // 1: reset, single coin_5, latency, hold-off length, audit
    rst = 1'b0;
    tick(2);
    chk("rst_coin_5", int'(coin_5), 0);
    chk("rst_coin_10", int'(coin_10), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_audit", int'(audit_total), 0);
    rst = 1'b1;
    tick(3);
    b5 = n5; bb = nbusy;
    raw_5 = 1'b1; k = cyc + 1;
    tick(10);
    raw_5 = 1'b0;
    tick(15);
    chk("t1_coin5_count", n5 - b5, 1);
    chk("t1_latency", last5, k + 6);
    chk("t1_busy_cycles", nbusy - bb, 3);
    chk("t1_audit", int'(audit_total), 5);

    // 2: short glitch filtered, clean coin_10 accepted
    do_reset();
    b10 = n10; br = nrej;
    raw_10 = 1'b1;
    tick(2);
    raw_10 = 1'b0;
    tick(12);
    chk("t2_glitch_coin10", n10 - b10, 0);
    raw_10 = 1'b1;
    tick(10);
    raw_10 = 1'b0;
    tick(15);
    chk("t2_coin10_count", n10 - b10, 1);
    chk("t2_reject_count", nrej - br, 0);
    chk("t2_audit", int'(audit_total), 10);

    // 3: simultaneous coins -> one reject, audit unchanged
    b5 = n5; b10 = n10; br = nrej;
    raw_5 = 1'b1; raw_10 = 1'b1;
    tick(10);
    raw_5 = 1'b0; raw_10 = 1'b0;
    tick(15);
    chk("t3_reject_count", nrej - br, 1);
    chk("t3_coin5_count", n5 - b5, 0);
    chk("t3_coin10_count", n10 - b10, 0);
    chk("t3_audit", int'(audit_total), 10);

    // 4: accept_en=0 -> reject at coin latency; then a coin_5 is accepted
    b5 = n5; b10 = n10; br = nrej;
    accept_en = 1'b0;
    raw_10 = 1'b1; k = cyc + 1;
    tick(10);
    raw_10 = 1'b0;
    tick(15);
    chk("t4_reject_count", nrej - br, 1);
    chk("t4_reject_latency", lastr, k + 6);
    chk("t4_coin10_count", n10 - b10, 0);
    accept_en = 1'b1;
    raw_5 = 1'b1;
    tick(10);
    raw_5 = 1'b0;
    tick(15);
    chk("t4_coin5_count", n5 - b5, 1);
    chk("t4_audit", int'(audit_total), 15);

    // 5: second coin event lands in HOLDOFF -> coin_5 then reject
    do_reset();
    b5 = n5; b10 = n10; br = nrej;
    raw_5 = 1'b1; k = cyc + 1;
    tick(1);
    raw_10 = 1'b1;
    tick(10);
    raw_5 = 1'b0; raw_10 = 1'b0;
    tick(15);
    chk("t5_coin5_cycle", last5, k + 6);
    chk("t5_reject_cycle", lastr, k + 7);
    chk("t5_coin5_count", n5 - b5, 1);
    chk("t5_reject_count", nrej - br, 1);
    chk("t5_coin10_count", n10 - b10, 0);
    chk("t5_audit", int'(audit_total), 5);

    // 6: audit saturation, then reset mid-debounce discards the coin
    do_reset();
    b10 = n10;
    for (int i = 1; i <= 26; i++) begin
      raw_10 = 1'b1;
      tick(10);
      raw_10 = 1'b0;
      tick(10);
      if (i == 25) chk("t6_audit_25", int'(audit_total), 250);
    end
    chk("t6_audit_26", int'(audit_total), 255);
    chk("t6_coin10_count", n10 - b10, 26);
    b5 = n5; br = nrej;
    raw_5 = 1'b1;
    tick(3);
    rst = 1'b0;
    raw_5 = 1'b0;
    tick(1);
    chk("t6_rst_coin_5", int'(coin_5), 0);
    chk("t6_rst_coin_10", int'(coin_10), 0);
    chk("t6_rst_reject", int'(reject), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_audit", int'(audit_total), 0);
    rst = 1'b1;
    tick(15);
    chk("t6_discarded_coin5", n5 - b5, 0);
    chk("t6_discarded_reject", nrej - br, 0);

    chk("exclusive_pulses", nexcl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
